uart_axi_master: RTL and testbench
==================================

UART_AXI_MASTER -- requirements
Module: uart_axi_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: inter-byte timeout in aclk cycles (used only with UART_AXI_TIMEOUT_EN).
REQ-002 SHALL have parameter ADDR_W, default 32: AXI address width.
REQ-003 SHALL have port aclk, input, 1: the single clock.
REQ-004 SHALL have port aresetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port rx_data, input, 8: received command byte.
REQ-006 SHALL have port rx_valid, input, 1: rx_data valid, one-cycle strobe.
REQ-007 SHALL have port rx_clr, output, 1: one-cycle acknowledge of a consumed rx byte.
REQ-008 SHALL have port tx_data, output, 8: response byte.
REQ-009 SHALL have port tx_wr_en, output, 1: one-cycle write strobe for tx_data.
REQ-010 SHALL have port tx_busy, input, 1: transmitter busy.
REQ-011 SHALL have port axi, AXI_LITE.master, -: drives awaddr/awvalid, wdata/wvalid/wlast, bready, araddr/arvalid, rready; samples the matching ready/valid/resp/data signals.

Function
REQ-012 SHALL parse frames: opcode byte, 4 address bytes MSB first, then for opcode 0x57 ('W') 4 data bytes MSB first; opcode 0x52 ('R') has no data bytes.
REQ-013 SHALL use states IDLE, ADDR, DATA, AW_W, B, AR, R, RESP, ERR.
REQ-014 In IDLE, rx_valid with 0x57 or 0x52 SHALL latch the opcode and go to ADDR; any other byte SHALL go to ERR.
REQ-015 SHALL pulse rx_clr exactly one cycle for every consumed byte, in the cycle after rx_valid is sampled.
REQ-016 ADDR SHALL shift in 4 bytes, then go to DATA for 'W' or to AR for 'R'; DATA SHALL shift in 4 bytes, then go to AW_W.
REQ-017 AW_W SHALL assert awvalid and wvalid together with wlast=1; each valid SHALL hold until its own ready is sampled high, independently; after both handshakes the FSM SHALL go to B.
REQ-018 B SHALL hold bready=1; on bvalid it SHALL latch bresp into status byte {6'b0,bresp} and go to RESP with 1 byte queued.
REQ-019 AR SHALL hold arvalid until arready; R SHALL hold rready=1, latch rdata on rvalid, and go to RESP with 4 bytes queued, MSB first.
REQ-020 RESP SHALL issue each queued byte with a one-cycle tx_wr_en only when tx_busy=0, wait at least 2 cycles between strobes so tx_busy can assert, then return to IDLE after the last byte.
REQ-021 ERR SHALL send the single byte 0xEE through the RESP mechanism, then return to IDLE.
REQ-022 rx bytes arriving in AW_W, B, AR, R, RESP or ERR SHALL be ignored and SHALL NOT be acknowledged.
REQ-023 SHALL NOT start a new frame until the response of the previous frame is fully sent.
REQ-024 A simultaneous ready on AW and W SHALL complete both handshakes in the same cycle.

Reset
REQ-025 On aresetn=0, asynchronously: state=IDLE; awvalid, wvalid, wlast, bready, arvalid, rready, rx_clr, tx_wr_en=0; tx_data, address and data registers=0.
REQ-026 Reset mid-frame or mid-transaction SHALL abandon it with no response byte; the first frame after reset SHALL parse normally.

Configuration
REQ-027 With UART_AXI_TIMEOUT_EN defined, a counter SHALL reload on each consumed byte in ADDR/DATA; if TIMEOUT_CYCLES cycles pass with no byte, the FSM SHALL discard the partial frame and go to ERR (sends 0xEE).
REQ-028 Without UART_AXI_TIMEOUT_EN, no counter SHALL exist and ADDR/DATA SHALL wait indefinitely.

Verification
REQ-029 Bytes 57 00 00 00 10 DE AD BE EF, slave OKAY -> awaddr=0x10 and wdata=0xDEADBEEF with wlast=1, then tx byte 0x00.
REQ-030 Bytes 52 00 00 00 04, slave rdata=0x12345678 -> araddr=0x04, then tx bytes 12 34 56 78 in order, each only while tx_busy=0.
REQ-031 Write where awready comes 3 cycles after wready and bresp=2'b10 -> each valid drops the cycle after its own handshake, then tx byte 0x02.
REQ-032 Byte 0x41 in IDLE -> tx byte 0xEE, no AXI activity, next valid frame completes.
REQ-033 With UART_AXI_TIMEOUT_EN and TIMEOUT_CYCLES=100: bytes 57 00 00, then silence -> 0xEE about 100 cycles later, no awvalid.
REQ-034 aresetn pulsed low while arvalid=1 -> arvalid=0 immediately, no tx strobe, the following read frame succeeds.

Source files
------------

// File: rtl/uart_axi_master_if.sv
// AXI-Lite bus bundle used by the UART command bridge (single 32-bit data beat,
// no write strobes/prot).
interface AXI_LITE #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic              wvalid;
  logic              wready;
  logic              wlast;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rvalid
  );
endinterface

// File: rtl/uart_axi_master.sv
// UART byte-stream to AXI-Lite master bridge: 'W' addr[4] data[4] / 'R' addr[4]
// frames, response bytes back on tx. Optional inter-byte timeout: UART_AXI_TIMEOUT_EN.
module uart_axi_master #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_clr,
  output logic [7:0] tx_data,
  output logic       tx_wr_en,
  input  logic       tx_busy,
  AXI_LITE.master    axi
);

  typedef enum logic [3:0] {
    IDLE, ADDR, DATA, AW_W, B, AR, R, RESP, ERR
  } state_t;

  state_t      state, state_n;
  logic        op_w;
  logic [1:0]  byte_cnt;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        aw_done, w_done;
  logic [31:0] resp_buf;
  logic [2:0]  resp_cnt;
  logic [1:0]  gap;
  logic        consume;
  logic        issue;
  logic        timeout;
  logic        in_frame;
  logic        aw_hs, w_hs;

  assign in_frame = (state == ADDR) || (state == DATA);

`ifdef UART_AXI_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_cnt <= '0;
    end else if (consume) begin
      to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
    end else if (in_frame && to_cnt != '0) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  assign timeout = (to_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  // Valids are decoded from state plus per-channel done flags so AW and W
  // retire independently and each drops the cycle after its own handshake.
  assign axi.awvalid = (state == AW_W) && !aw_done;
  assign axi.wvalid  = (state == AW_W) && !w_done;
  assign axi.wlast   = (state == AW_W) && !w_done;
  assign axi.bready  = (state == B);
  assign axi.arvalid = (state == AR);
  assign axi.rready  = (state == R);
  assign axi.awaddr  = ADDR_W'(addr_q);
  assign axi.araddr  = ADDR_W'(addr_q);
  assign axi.wdata   = data_q;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    consume = 1'b0;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          consume = 1'b1;
          state_n = (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : ERR;
        end
      end
      ADDR: begin
        if (rx_valid) begin
          consume = 1'b1;
          if (byte_cnt == 2'd3) state_n = op_w ? DATA : AR;
        end else if (timeout) begin
          state_n = ERR;
        end
      end
      DATA: begin
        if (rx_valid) begin
          consume = 1'b1;
          if (byte_cnt == 2'd3) state_n = AW_W;
        end else if (timeout) begin
          state_n = ERR;
        end
      end
      AW_W: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = B;
      end
      B: begin
        if (axi.bvalid) state_n = RESP;
      end
      AR: begin
        if (axi.arready) state_n = R;
      end
      R: begin
        if (axi.rvalid) state_n = RESP;
      end
      RESP: begin
        if (resp_cnt != 3'd0 && gap == 2'd0 && !tx_busy) begin
          issue = 1'b1;
          if (resp_cnt == 3'd1) state_n = IDLE;
        end
      end
      ERR: begin
        state_n = RESP;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_clr   <= 1'b0;
      tx_wr_en <= 1'b0;
      tx_data  <= '0;
      op_w     <= 1'b0;
      byte_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      resp_buf <= '0;
      resp_cnt <= '0;
      gap      <= '0;
    end else begin
      rx_clr   <= consume;
      tx_wr_en <= issue;

      if (state == IDLE && consume) op_w <= (rx_data == 8'h57);

      if (in_frame && consume) begin
        byte_cnt <= byte_cnt + 1'b1;
      end else if (!in_frame) begin
        byte_cnt <= '0;
      end

      if (state == ADDR && consume) addr_q <= {addr_q[23:0], rx_data};
      if (state == DATA && consume) data_q <= {data_q[23:0], rx_data};

      if (state == AW_W) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end

      // Response bytes are shifted out of the top of resp_buf, MSB first.
      if (state == B && axi.bvalid) begin
        resp_buf <= {6'b0, axi.bresp, 24'h0};
        resp_cnt <= 3'd1;
      end else if (state == R && axi.rvalid) begin
        resp_buf <= axi.rdata;
        resp_cnt <= 3'd4;
      end else if (state == ERR) begin
        resp_buf <= {8'hEE, 24'h0};
        resp_cnt <= 3'd1;
      end else if (issue) begin
        tx_data  <= resp_buf[31:24];
        resp_buf <= {resp_buf[23:0], 8'h00};
        resp_cnt <= resp_cnt - 1'b1;
      end

      // Two dead cycles after each strobe give the transmitter time to raise tx_busy.
      if (issue) begin
        gap <= 2'd2;
      end else if (gap != 2'd0) begin
        gap <= gap - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_axi_master.sv
// Scoreboard bench for uart_axi_master: AXI-Lite slave and UART tx models,
// expected AXI addresses/data and tx bytes queued at stimulus time.
module tb_uart_axi_master;

`ifdef UART_AXI_TIMEOUT_EN
  localparam int unsigned TO = 100;
`else
  localparam int unsigned TO = 50000;
`endif

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_clr;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       tx_busy;

  AXI_LITE #(.ADDR_W(32)) axi ();

  uart_axi_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_clr   (rx_clr),
    .tx_data  (tx_data),
    .tx_wr_en (tx_wr_en),
    .tx_busy  (tx_busy),
    .axi      (axi)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_ar[$];

  int          aw_delay = 0;
  int          w_delay  = 0;
  int          ar_delay = 0;
  int          busy_len = 4;
  logic [1:0]  cur_bresp = 2'b00;
  logic [31:0] cur_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // AXI-Lite slave plus UART transmitter model, evaluated on falling edges.
  initial begin
    int aw_cnt, w_cnt, ar_cnt, busy_cnt, cyc, last_strobe;
    bit aw_f, w_f, ar_f, aw_dn, w_dn, r_pend;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; busy_cnt = 0; cyc = 0; last_strobe = -100;
    aw_f = 0; w_f = 0; ar_f = 0; aw_dn = 0; w_dn = 0; r_pend = 0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    tx_busy = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; busy_cnt = 0;
        aw_f = 0; w_f = 0; ar_f = 0; aw_dn = 0; w_dn = 0; r_pend = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
        tx_busy = 1'b0;
        continue;
      end

      if (tx_wr_en) begin
        check("tx_busy_at_strobe", 32'(tx_busy), 32'(0));
        check("tx_gap", 32'((cyc - last_strobe) >= 3), 32'(1));
        last_strobe = cyc;
        if (exp_tx.size() == 0) check("tx_unexpected", 32'(tx_wr_en), 32'(0));
        else                    check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        if (busy_len > 0) begin
          tx_busy  = 1'b1;
          busy_cnt = busy_len;
        end
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end

      if (aw_f) begin
        check("aw_drop", 32'(axi.awvalid), 32'(0));
        aw_f = 0;
      end
      axi.awready = 1'b0;
      if (axi.awvalid) begin
        if (aw_cnt >= aw_delay) begin
          axi.awready = 1'b1; aw_f = 1; aw_dn = 1; aw_cnt = 0;
          if (exp_aw.size() == 0) check("aw_unexpected", 32'(axi.awvalid), 32'(0));
          else                    check("awaddr", axi.awaddr, exp_aw.pop_front());
        end else begin
          aw_cnt++;
        end
      end

      if (w_f) begin
        check("w_drop", 32'(axi.wvalid), 32'(0));
        w_f = 0;
      end
      axi.wready = 1'b0;
      if (axi.wvalid) begin
        if (w_cnt >= w_delay) begin
          axi.wready = 1'b1; w_f = 1; w_dn = 1; w_cnt = 0;
          check("wlast", 32'(axi.wlast), 32'(1));
          if (exp_w.size() == 0) check("w_unexpected", 32'(axi.wvalid), 32'(0));
          else                   check("wdata", axi.wdata, exp_w.pop_front());
        end else begin
          w_cnt++;
        end
      end

      if (axi.bvalid) begin
        axi.bvalid = 1'b0;
      end else if (aw_dn && w_dn && axi.bready) begin
        axi.bvalid = 1'b1; axi.bresp = cur_bresp; aw_dn = 0; w_dn = 0;
      end

      if (ar_f) begin
        check("ar_drop", 32'(axi.arvalid), 32'(0));
        ar_f = 0;
      end
      axi.arready = 1'b0;
      if (axi.arvalid) begin
        if (ar_cnt >= ar_delay) begin
          axi.arready = 1'b1; ar_f = 1; r_pend = 1; ar_cnt = 0;
          if (exp_ar.size() == 0) check("ar_unexpected", 32'(axi.arvalid), 32'(0));
          else                    check("araddr", axi.araddr, exp_ar.pop_front());
        end else begin
          ar_cnt++;
        end
      end

      if (axi.rvalid) begin
        axi.rvalid = 1'b0;
      end else if (r_pend && axi.rready) begin
        axi.rvalid = 1'b1; axi.rdata = cur_rdata; r_pend = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic ack);
    @(negedge aclk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge aclk);
    rx_valid = 1'b0;
    check("rx_clr", 32'(rx_clr), 32'(ack));
    @(negedge aclk);
    check("rx_clr_pulse", 32'(rx_clr), 32'(0));
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    send_byte(op, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8], 1'b1);
    if (op == 8'h57) begin
      for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8], 1'b1);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_aw.size() != 0 || exp_w.size() != 0 ||
            exp_ar.size() != 0) && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check("done_in_time", 32'(n < budget), 32'(1));
    repeat (busy_len + 4) @(negedge aclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rx_data  = '0;
    rx_valid = 1'b0;
    aresetn  = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_tx_wr_en", 32'(tx_wr_en), 32'(0));
    check("rst_rx_clr", 32'(rx_clr), 32'(0));
    check("rst_tx_data", 32'(tx_data), 32'(0));
    check("rst_awvalid", 32'(axi.awvalid), 32'(0));
    check("rst_wvalid", 32'(axi.wvalid), 32'(0));
    check("rst_wlast", 32'(axi.wlast), 32'(0));
    check("rst_bready", 32'(axi.bready), 32'(0));
    check("rst_arvalid", 32'(axi.arvalid), 32'(0));
    check("rst_rready", 32'(axi.rready), 32'(0));
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Write, AW and W ready together, OKAY response
    exp_aw.push_back(32'h10);
    exp_w.push_back(32'hDEADBEEF);
    exp_tx.push_back(8'h00);
    send_frame(8'h57, 32'h10, 32'hDEADBEEF);
    wait_done(500);

    // Read, with a stray rx byte during the transaction that must be ignored
    ar_delay  = 1;
    cur_rdata = 32'h12345678;
    exp_ar.push_back(32'h04);
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
    send_frame(8'h52, 32'h04, 32'h0);
    send_byte(8'h99, 1'b0);
    wait_done(500);

    // Write, awready 3 cycles after wready, SLVERR
    aw_delay  = 3;
    w_delay   = 0;
    cur_bresp = 2'b10;
    exp_aw.push_back(32'h0000_0020);
    exp_w.push_back(32'hCAFEF00D);
    exp_tx.push_back(8'h02);
    send_frame(8'h57, 32'h20, 32'hCAFEF00D);
    wait_done(500);
    aw_delay  = 0;
    cur_bresp = 2'b00;

    // Bad opcode, then a read with an idle transmitter (exercises the strobe gap)
    exp_tx.push_back(8'hEE);
    send_byte(8'h41, 1'b1);
    wait_done(500);
    busy_len  = 0;
    cur_rdata = 32'h89ABCDEF;
    exp_ar.push_back(32'hA0B0C0D0);
    exp_tx.push_back(8'h89); exp_tx.push_back(8'hAB);
    exp_tx.push_back(8'hCD); exp_tx.push_back(8'hEF);
    send_frame(8'h52, 32'hA0B0C0D0, 32'h0);
    wait_done(500);
    busy_len = 4;

    // Reset while arvalid is held
    ar_delay = 20;
    send_frame(8'h52, 32'h08, 32'h0);
    n = 0;
    while (!axi.arvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("arvalid_seen", 32'(axi.arvalid), 32'(1));
    #2;
    aresetn = 1'b0;
    #1;
    check("arvalid_async_rst", 32'(axi.arvalid), 32'(0));
    check("tx_wr_en_async_rst", 32'(tx_wr_en), 32'(0));
    repeat (2) @(negedge aclk);
    aresetn  = 1'b1;
    ar_delay = 1;
    repeat (2) @(negedge aclk);
    cur_rdata = 32'hA5A55A5A;
    exp_ar.push_back(32'h0C);
    exp_tx.push_back(8'hA5); exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'h5A);
    send_frame(8'h52, 32'h0C, 32'h0);
    wait_done(500);

`ifdef UART_AXI_TIMEOUT_EN
    // Partial frame then silence: 0xEE about TIMEOUT_CYCLES later, no AXI traffic
    exp_tx.push_back(8'hEE);
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    n = 0;
    while (exp_tx.size() != 0 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    check("timeout_latency", 32'(n >= 90 && n <= 115), 32'(1));
    repeat (busy_len + 4) @(negedge aclk);
    exp_aw.push_back(32'h44);
    exp_w.push_back(32'h01020304);
    exp_tx.push_back(8'h00);
    send_frame(8'h57, 32'h44, 32'h01020304);
    wait_done(500);
`endif

    check("tx_left", 32'(exp_tx.size()), 32'(0));
    check("aw_left", 32'(exp_aw.size()), 32'(0));
    check("ar_left", 32'(exp_ar.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
